// File: rtl/core_pkg.sv
// Shared hazard/forwarding definitions for the RV32I core: optype and forward-select
// encodings plus the shadow-pipeline entry tracked for the EX and MEM stages.
package core_pkg;

  localparam int HZ_REG_AW = 5;
  localparam int HZ_FWD_W  = 2;

  localparam logic [1:0] HZ_NONE = 2'b00;
  localparam logic [1:0] HZ_ALU  = 2'b01;
  localparam logic [1:0] HZ_LOAD = 2'b10;
  localparam logic [1:0] HZ_BR   = 2'b11;

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_EX      = 2'b01;
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;
  localparam logic [1:0] FWD_MEM_LD  = 2'b11;

  typedef struct packed {
    logic                 wr;
    logic                 is_load;
    logic [HZ_REG_AW-1:0] rd;
  } shadow_t;

  localparam shadow_t SHADOW_BUBBLE = '0;

  function automatic logic is_load_op(input logic [1:0] optype);
    return optype == HZ_LOAD;
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-source producer match and forward-select priority (EX over MEM).
// Also flags a match against a load still in EX, which drives the load-use stall.
module hazard_fwd_sel
  import core_pkg::*;
#(
  parameter int REG_AW = HZ_REG_AW,
  parameter int FWD_W  = HZ_FWD_W
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic              use_i,
  input  shadow_t           ex_i,
  input  shadow_t           mem_i,
  output logic [FWD_W-1:0]  sel_o,
  output logic              ld_hit_o
);

  logic match_ex;
  logic match_mem;

  // x0 is hardwired zero, so a write to it never produces a forwardable value
  assign match_ex  = use_i & ex_i.wr  & (ex_i.rd  != '0) & (ex_i.rd  == rs_i);
  assign match_mem = use_i & mem_i.wr & (mem_i.rd != '0) & (mem_i.rd == rs_i);

  always_comb begin
    sel_o = FWD_RF;
    if (match_ex && !ex_i.is_load) begin
      sel_o = FWD_EX;
    end else if (match_mem && !mem_i.is_load) begin
      sel_o = FWD_MEM_ALU;
    end else if (match_mem) begin
      sel_o = FWD_MEM_LD;
    end
  end

  assign ld_hit_o = match_ex & ex_i.is_load;

endmodule

// File: rtl/hazard_fwd_unit.sv
// ID-stage hazard unit: shadow EX/MEM producer tracking, forward selects, load-use stall
// and redirect flush. Define HAZARD_PERF_EN to add stall_cnt/flush_cnt event counters.
module hazard_fwd_unit
  import core_pkg::*;
#(
  parameter int REG_AW = HZ_REG_AW,
  parameter int FWD_W  = HZ_FWD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        optype_ID,
  input  logic              valid_ID,
  input  logic              RegWrite_ID,
  input  logic [REG_AW-1:0] rd_ID,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic              rs1use_ID,
  input  logic              rs2use_ID,
  input  logic              redirect_ID,
  output logic [FWD_W-1:0]  forward_ctrl_A,
  output logic [FWD_W-1:0]  forward_ctrl_B,
  output logic              PC_EN_IF,
  output logic              reg_FD_EN,
  output logic              reg_FD_flush,
  output logic              reg_DE_flush
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  shadow_t ex_q, ex_d;
  shadow_t mem_q;
  logic    ld_hit_a, ld_hit_b;
  logic    stall;

  hazard_fwd_sel #(.REG_AW(REG_AW), .FWD_W(FWD_W)) u_sel_a (
    .rs_i     (rs1_ID),
    .use_i    (rs1use_ID),
    .ex_i     (ex_q),
    .mem_i    (mem_q),
    .sel_o    (forward_ctrl_A),
    .ld_hit_o (ld_hit_a)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW), .FWD_W(FWD_W)) u_sel_b (
    .rs_i     (rs2_ID),
    .use_i    (rs2use_ID),
    .ex_i     (ex_q),
    .mem_i    (mem_q),
    .sel_o    (forward_ctrl_B),
    .ld_hit_o (ld_hit_b)
  );

  assign stall = valid_ID & (ld_hit_a | ld_hit_b);

  // A stall always inserts the ID/EX bubble, so stall alone decides what EX captures
  always_comb begin
    ex_d = SHADOW_BUBBLE;
    if (!stall) begin
      ex_d.wr      = RegWrite_ID & valid_ID;
      ex_d.is_load = is_load_op(optype_ID);
      ex_d.rd      = rd_ID;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= SHADOW_BUBBLE;
      mem_q <= SHADOW_BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
    end
  end

  assign PC_EN_IF     = ~stall;
  assign reg_FD_EN    = ~stall;
  assign reg_DE_flush = stall;
  assign reg_FD_flush = rst_n & valid_ID & redirect_ID & ~stall;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall)        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (reg_FD_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
